fifo_writer_skid: RTL
=====================

FIFO_WRITER_SKID -- requirements
Module: fifo_writer_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter NUM_BUFFS, default 3, meaning skid-buffer depth in words (legal range 1..7).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port in_stream_data, input, WIDTH, meaning the producer word.
REQ-006 SHALL have port in_stream_valid, input, 1, meaning the producer word is valid.
REQ-007 SHALL have port ou_stream_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 SHALL have port ou_fifo_data, output, WIDTH, meaning the word written to the downstream FIFO.
REQ-009 SHALL have port ou_fifo_wren, output, 1, meaning the FIFO write enable.
REQ-010 SHALL have port in_fifo_full, input, 1, meaning the downstream FIFO is full; it is sampled combinationally.

Function
REQ-011 SHALL define accept = in_stream_valid & ou_stream_ready.
REQ-012 SHALL drive ou_stream_ready = (count < NUM_BUFFS), from registers only, with no path from in_fifo_full.
REQ-013 SHALL drive ou_fifo_wren = !in_fifo_full & (count > 0 | in_stream_valid & ou_stream_ready).
REQ-014 SHALL drive ou_fifo_data = oldest buffered word when count > 0, else in_stream_data (zero-latency pass-through); when ou_fifo_wren = 0 it is don't-care.
REQ-015 SHALL hold buffered words in a circular buffer of NUM_BUFFS entries with read and write pointers that wrap from NUM_BUFFS-1 to 0.
REQ-016 SHALL, when count = 0, pass an accepted word straight through if writing is possible, leaving count unchanged.
REQ-017 SHALL, when count = 0 and in_fifo_full = 1, store the accepted word and increment count.
REQ-018 SHALL, when count > 0, pop the oldest word on each write and push on each accept: count_next = count + accept - wren; a simultaneous push and pop leaves count unchanged.
REQ-019 SHALL preserve word order exactly; no word is dropped or duplicated.
REQ-020 SHALL implement FSM states EMPTY (count = 0), PARTIAL (0 < count < NUM_BUFFS) and FULL (count = NUM_BUFFS), with the state registered alongside count.
REQ-021 SHALL apply these transitions: EMPTY->PARTIAL on store; PARTIAL->EMPTY on the last pop without a push; PARTIAL->FULL when the push fills the buffer; FULL->PARTIAL on a pop.
REQ-022 SHALL, in FULL with a pop in the same cycle, keep ready low that cycle and raise it the next cycle.
REQ-023 SHALL never assert ou_fifo_wren while in_fifo_full = 1.

Reset
REQ-024 SHALL, on rst = 1 at a clock edge, clear count, pointers and state to 0/EMPTY; ou_stream_ready = 1 and ou_fifo_wren = 0 from the next cycle.
REQ-025 SHALL discard all buffered words on reset mid-operation, with no write in the reset cycle.
REQ-026 SHALL NOT be required to reset the buffer storage contents.

Configuration
REQ-027 SHALL, with FIFO_WRITER_WORDCNT_EN defined, add output ou_word_count [31:0] counting ou_fifo_wren cycles, wrapping 0xFFFFFFFF->0, and cleared to 0 by reset.
REQ-028 SHALL, with FIFO_WRITER_WORDCNT_EN undefined, omit the port and the counter entirely.

Structure
REQ-029 SHALL take the FSM state enum (EMPTY/PARTIAL/FULL) and the default WIDTH constant from shared package fifo_stream_pkg, which is also used by the FIFO reader.
REQ-030 SHALL place the circular buffer storage and pointers in sub-module stream_skid_buf; the top level holds the FSM, count and handshake logic.

Verification
REQ-031 SHALL cover pass-through: full = 0, valid every cycle with 1,2,3 -> wren = 1 in the same cycles, data 1,2,3, count stays 0.
REQ-032 SHALL cover back-pressure: full = 1 for 5 cycles, valid with 10,11,12,13 -> 10,11,12 buffered, ready = 0 after the 3rd; on full = 0, writes 10,11,12 then 13 in consecutive cycles.
REQ-033 SHALL cover simultaneous push and pop: count = 2, full = 0, valid with 0xA5 -> oldest word written, count remains 2, 0xA5 written 2 cycles later.
REQ-034 SHALL cover reset mid-operation: count = 3, assert rst for 1 cycle -> next cycle count = 0, ready = 1, wren = 0, and old words are never written.
REQ-035 SHALL cover pointer wrap: 1000 random words with random full/valid, NUM_BUFFS = 3 -> output sequence identical to input, and wren never high with full.
REQ-036 SHALL cover the counter with FIFO_WRITER_WORDCNT_EN: counter preloaded via force to 0xFFFFFFFE, 3 writes -> ou_word_count = 1.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO writer/reader stream skid blocks:
// occupancy state enum, default word width and a pointer-width helper.
package fifo_stream_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } skid_state_e;

  // Bits needed to index n distinct values, never less than one.
  function automatic int bits_for(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_writer_skid_if.sv
// Producer stream and downstream FIFO write handshake for fifo_writer_skid.
interface fifo_writer_skid_if import fifo_stream_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] in_stream_data;
  logic             in_stream_valid;
  logic             ou_stream_ready;
  logic [WIDTH-1:0] ou_fifo_data;
  logic             ou_fifo_wren;
  logic             in_fifo_full;

  modport slave (
    input  in_stream_data, in_stream_valid, in_fifo_full,
    output ou_stream_ready, ou_fifo_data, ou_fifo_wren
  );

  modport master (
    output in_stream_data, in_stream_valid, in_fifo_full,
    input  ou_stream_ready, ou_fifo_data, ou_fifo_wren
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Circular word store for the writer skid: push at wr_ptr, oldest word
// always visible at rdata, pointers wrap NUM_BUFFS-1 -> 0.
module stream_skid_buf import fifo_stream_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_BUFFS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int PTR_W = bits_for(NUM_BUFFS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BUFFS - 1);

  logic [WIDTH-1:0] mem [NUM_BUFFS];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fifo_writer_skid.sv
// Stream-to-FIFO writer with a NUM_BUFFS-deep skid buffer and zero-latency pass-through.
// Optional FIFO_WRITER_WORDCNT_EN adds ou_word_count, a free-running count of FIFO writes.
//
// state   | meaning
// EMPTY   | count = 0, words pass straight through when the FIFO has room
// PARTIAL | 0 < count < NUM_BUFFS, oldest buffered word goes out first
// FULL    | count = NUM_BUFFS, producer is held off
module fifo_writer_skid import fifo_stream_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_BUFFS = 3
) (
  input  logic clk,
  input  logic rst,
  fifo_writer_skid_if.slave bus
`ifdef FIFO_WRITER_WORDCNT_EN
  ,
  output logic [31:0] ou_word_count
`endif
);

  localparam int CNT_W = bits_for(NUM_BUFFS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_BUFFS);

  skid_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             buffered;
  logic             ready;
  logic             accept;
  logic             wren;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  // Ready comes from the registered state only, never from in_fifo_full.
  assign buffered = (state_q != EMPTY);
  assign ready    = (state_q != FULL);
  assign accept   = bus.in_stream_valid & ready;
  assign wren     = !rst & !bus.in_fifo_full & (buffered | accept);
  assign pop      = wren & buffered;
  assign push     = accept & (buffered | bus.in_fifo_full);

  assign bus.ou_stream_ready = ready;
  assign bus.ou_fifo_wren    = wren;
  assign bus.ou_fifo_data    = buffered ? head : bus.in_stream_data;

  stream_skid_buf #(
    .WIDTH     (WIDTH),
    .NUM_BUFFS (NUM_BUFFS)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_stream_data),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case (state_q)
      EMPTY: begin
        if (push) state_d = (count_d == CNT_MAX) ? FULL : PARTIAL;
      end
      PARTIAL: begin
        if (count_d == '0)          state_d = EMPTY;
        else if (count_d == CNT_MAX) state_d = FULL;
      end
      FULL: begin
        if (pop) state_d = (count_d == '0) ? EMPTY : PARTIAL;
      end
      default: state_d = EMPTY;
    endcase
  end

`ifdef FIFO_WRITER_WORDCNT_EN
  logic [31:0] word_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)       word_cnt_q <= '0;
    else if (wren) word_cnt_q <= word_cnt_q + 32'd1;
  end

  assign ou_word_count = word_cnt_q;
`endif

endmodule
